// File: rtl/bus_master_if_if.sv
// Bus-side signal bundle for one bus master port.
// The master modport drives request/strobe/address/data and consumes
// grant, read data and ready. The slave modport is the mirror image,
// for arbiter/slave-mux models on the other side.
interface bus_master_if_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) ();
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/bus_master_if.sv
// Master-side bus interface for a CPU pipeline stage.
// Turns a core access (as_/rw/addr/wr_data) into request -> grant ->
// one-cycle address strobe -> wait for ready, and holds busy high so the
// pipeline stalls for the whole transaction. All bus outputs are registered.
// Optional feature macro: BUS_IF_TIMEOUT_EN adds an ACCESS-phase timeout
// (TIMEOUT_CYC cycles, 1..255) that aborts the access and pulses err.
module bus_master_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
`ifdef BUS_IF_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err,
    bus_master_if_if.master   bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_STALL  = 2'd3;

    localparam logic READ = 1'b1;

    logic [1:0]        r_state;
    logic              r_req_;
    logic              r_as_;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_rd_buf;

    logic w_start;
    logic w_rdy;
    logic w_done;
    logic w_timeout;

`ifdef BUS_IF_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] r_cnt;
    logic       r_err;

    // Expiry is the TIMEOUT_CYC-th ACCESS cycle without ready; ready in that
    // same cycle takes priority because w_timeout requires rdy_ high.
    assign w_timeout = (r_state == ST_ACCESS) && bus.bus_rdy_ && (r_cnt == TO_LAST);
    assign err       = r_err;

    // Count ACCESS cycles spent waiting for the slave; one-cycle err pulse on expiry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state == ST_REQ && !bus.bus_grnt_) begin
                r_cnt <= 8'd0;
            end else if (r_state == ST_ACCESS && bus.bus_rdy_) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    assign w_start = (r_state == ST_IDLE) && !as_ && !flush;
    assign w_rdy   = (r_state == ST_ACCESS) && !bus.bus_rdy_;
    assign w_done  = w_rdy || w_timeout;

    // Stall the pipeline from the accepting IDLE cycle until the access ends.
    assign busy = w_start || (r_state == ST_REQ) || (r_state == ST_ACCESS);

    assign rd_data         = r_rd_buf;
    assign bus.bus_req_    = r_req_;
    assign bus.bus_as_     = r_as_;
    assign bus.bus_rw      = r_rw;
    assign bus.bus_addr    = r_addr;
    assign bus.bus_wr_data = r_wr_data;

    // Transaction FSM and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_req_    <= 1'b1;
            r_as_     <= 1'b1;
            r_rw      <= READ;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_buf  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // flush suppresses a new request even when as_ is low
                    if (w_start) begin
                        r_addr    <= addr;
                        r_rw      <= rw;
                        r_wr_data <= wr_data;
                        r_req_    <= 1'b0;
                        r_state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!bus.bus_grnt_) begin
                        r_as_   <= 1'b0;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // bus_req_ stays low here so the arbiter keeps us granted
                    r_as_ <= 1'b1;
                    if (w_done) begin
                        if (w_rdy) begin
                            if (r_rw == READ) begin
                                r_rd_buf <= bus.bus_rd_data;
                            end
                        end else begin
                            r_rd_buf <= '0;
                        end
                        r_req_    <= 1'b1;
                        r_addr    <= '0;
                        r_wr_data <= '0;
                        r_rw      <= READ;
                        r_state   <= stall ? ST_STALL : ST_IDLE;
                    end
                end
                ST_STALL: begin
                    if (!stall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed vector table, hand-written
// corner sequences (flush, stall, mid-transaction reset, timeout) and random
// transactions. The arbiter/slave are driven on a fixed schedule derived from
// the latency rules, so every expected output is known per cycle.
module tb_bus_master_if;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              err;

    bus_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_master_if #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
`ifdef BUS_IF_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(4)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .flush   (flush),
        .addr    (addr),
        .as_     (as_),
        .rw      (rw),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .busy    (busy),
        .err     (err),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          txn_no = 0;
    logic [31:0] model_rd = 32'd0;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gwait;
        int          rwait;
        logic [31:0] exp_rd;
        int          exp_req_low;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Registered outputs expected when no transaction is outstanding.
    task automatic chk_quiet(input string tag);
        chk({tag, "_req_"},  32'(bus.bus_req_), 32'd1);
        chk({tag, "_as_"},   32'(bus.bus_as_), 32'd1);
        chk({tag, "_rw"},    32'(bus.bus_rw), 32'd1);
        chk({tag, "_addr"},  32'(bus.bus_addr), 32'd0);
        chk({tag, "_wdata"}, bus.bus_wr_data, 32'd0);
        chk({tag, "_rd"},    rd_data, model_rd);
    endtask

    // One complete transaction starting in the current (IDLE) cycle.
    // g = grant wait cycles, r = ready wait cycles.
    task automatic run_txn(input logic t_rw, input logic [29:0] t_addr,
                           input logic [31:0] t_wd, input logic [31:0] t_rd,
                           input int g, input int r, input logic stall_last,
                           input logic [31:0] exp_rd, input int exp_low);
        int low = 0;
        as_ = 1'b0; rw = t_rw; addr = t_addr; wr_data = t_wd; flush = 1'b0;
        stall = 1'($urandom); bus.bus_grnt_ = 1'b1;
        bus.bus_rdy_ = 1'($urandom); bus.bus_rd_data = $urandom;
        settle();
        chk("busy_start", 32'(busy), 32'd1);
        for (int i = 0; i <= g; i++) begin
            step();
            chk("req_in_req", 32'(bus.bus_req_), 32'd0);
            chk("as_in_req",  32'(bus.bus_as_), 32'd1);
            chk("addr_in_req", 32'(bus.bus_addr), 32'(t_addr));
            chk("rw_in_req",  32'(bus.bus_rw), 32'(t_rw));
            chk("err_in_req", 32'(err), 32'd0);
            if (bus.bus_req_ === 1'b0) low++;
            as_ = 1'($urandom); flush = 1'($urandom); stall = 1'($urandom);
            addr = 30'($urandom); rw = 1'($urandom); wr_data = $urandom;
            bus.bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
            bus.bus_rdy_ = 1'($urandom); bus.bus_rd_data = $urandom;
            settle();
            chk("busy_req", 32'(busy), 32'd1);
        end
        for (int k = 0; k <= r; k++) begin
            step();
            chk("req_in_acc", 32'(bus.bus_req_), 32'd0);
            chk("as_in_acc",  32'(bus.bus_as_), (k == 0) ? 32'd0 : 32'd1);
            chk("addr_in_acc", 32'(bus.bus_addr), 32'(t_addr));
            chk("rw_in_acc",  32'(bus.bus_rw), 32'(t_rw));
            chk("wdata_in_acc", bus.bus_wr_data, t_wd);
            chk("err_in_acc", 32'(err), 32'd0);
            if (bus.bus_req_ === 1'b0) low++;
            as_ = 1'($urandom); flush = 1'($urandom);
            addr = 30'($urandom); rw = 1'($urandom); wr_data = $urandom;
            stall = (k == r) ? stall_last : 1'($urandom);
            bus.bus_grnt_ = 1'($urandom);
            bus.bus_rdy_ = (k == r) ? 1'b0 : 1'b1;
            bus.bus_rd_data = (k == r) ? t_rd : $urandom;
            settle();
            chk("busy_acc", 32'(busy), 32'd1);
        end
        step();
        model_rd = exp_rd;
        chk_quiet("done");
        chk("done_err", 32'(err), 32'd0);
        chk("req_low_cycles", 32'(low), 32'(exp_low));
        as_ = 1'b1; flush = 1'b0; bus.bus_rdy_ = 1'b1; bus.bus_grnt_ = 1'b1;
        if (!stall_last) stall = 1'b0;
        settle();
        chk("busy_done", 32'(busy), 32'd0);
        $display("txn %0d rw=%0d addr=%h wd=%h g=%0d r=%0d rd_data=%h req_low=%0d",
                 txn_no, t_rw, t_addr, t_wd, g, r, rd_data, low);
        txn_no++;
    endtask

    initial begin
        // Directed vectors; expected read buffer and request-low length
        // (REQ cycles 1+gwait, ACCESS cycles 1+rwait) written out by hand.
        vecs[0] = '{1'b1, 30'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 2};
        vecs[1] = '{1'b0, 30'h0000_0010, 32'h1234_5678, 32'hCAFE_F00D, 4, 1, 32'hDEAD_BEEF, 7};
        vecs[2] = '{1'b1, 30'h3FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 0, 32'h0000_0000, 3};
        vecs[3] = '{1'b1, 30'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3, 32'hFFFF_FFFF, 5};
        vecs[4] = '{1'b0, 30'h2AAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 2, 2, 32'hFFFF_FFFF, 6};

        reset = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
        addr = '0; wr_data = '0;
        bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = '0;

        // Reset state
        step();
        step();
        chk_quiet("reset");
        chk("reset_err", 32'(err), 32'd0);
        reset = 1'b1;
        settle();
        chk("reset_busy", 32'(busy), 32'd0);

        // Table-driven transactions, back-to-back
        foreach (vecs[i]) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                    vecs[i].gwait, vecs[i].rwait, 1'b0, vecs[i].exp_rd, vecs[i].exp_req_low);
        end

        // flush beats as_ in IDLE
        as_ = 1'b0; flush = 1'b1; rw = 1'b0; addr = 30'h123; wr_data = 32'h77;
        settle();
        chk("flush_busy", 32'(busy), 32'd0);
        step();
        chk("flush_req_", 32'(bus.bus_req_), 32'd1);
        chk("flush_addr", 32'(bus.bus_addr), 32'd0);
        as_ = 1'b1; flush = 1'b0;
        settle();
        chk("flush_busy2", 32'(busy), 32'd0);

        // Read completing under stall: result held, as_ refused while in STALL
        run_txn(1'b1, 30'h0000_0040, 32'h0, 32'h0BAD_CAFE, 1, 1, 1'b1, 32'h0BAD_CAFE, 4);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_req_", 32'(bus.bus_req_), 32'd1);
            chk("stall_rd", rd_data, 32'h0BAD_CAFE);
            as_ = 1'b0;
            settle();
            chk("stall_busy", 32'(busy), 32'd0);
        end
        step();
        chk("stall_no_accept", 32'(bus.bus_req_), 32'd1);
        stall = 1'b0;
        settle();
        chk("stall_exit_busy", 32'(busy), 32'd0);
        step();
        chk("stall_exit_req_", 32'(bus.bus_req_), 32'd1);
        chk("stall_exit_rd", rd_data, 32'h0BAD_CAFE);
        as_ = 1'b1;
        settle();
        $display("txn %0d stall hold sequence rd_data=%h", txn_no, rd_data);
        txn_no++;

        // Reset while in ACCESS: response in the reset cycle is discarded
        as_ = 1'b0; rw = 1'b1; addr = 30'h155; wr_data = '0; flush = 1'b0; stall = 1'b0;
        step();
        chk("rst_mid_req", 32'(bus.bus_req_), 32'd0);
        as_ = 1'b1; bus.bus_grnt_ = 1'b0;
        step();
        chk("rst_mid_as", 32'(bus.bus_as_), 32'd0);
        bus.bus_grnt_ = 1'b1;
        step();
        reset = 1'b0; bus.bus_rdy_ = 1'b0; bus.bus_rd_data = 32'hA5A5_A5A5;
        step();
        reset = 1'b1; bus.bus_rdy_ = 1'b1;
        model_rd = 32'd0;
        chk_quiet("rst_mid");
        settle();
        chk("rst_mid_busy", 32'(busy), 32'd0);
        step();
        chk("rst_mid_after", 32'(bus.bus_req_), 32'd1);
        $display("txn %0d reset in ACCESS rd_data=%h", txn_no, rd_data);
        txn_no++;

`ifdef BUS_IF_TIMEOUT_EN
        // Ready never arrives: abort after 4 ACCESS cycles
        run_txn(1'b1, 30'h20, 32'h0, 32'h1111_2222, 0, 0, 1'b0, 32'h1111_2222, 2);
        as_ = 1'b0; rw = 1'b1; addr = 30'h99;
        step();
        as_ = 1'b1; bus.bus_grnt_ = 1'b0;
        step();
        bus.bus_grnt_ = 1'b1;
        chk("to_err_a1", 32'(err), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("to_req_wait", 32'(bus.bus_req_), 32'd0);
            chk("to_err_wait", 32'(err), 32'd0);
        end
        step();
        model_rd = 32'd0;
        chk("to_err", 32'(err), 32'd1);
        chk_quiet("to");
        settle();
        chk("to_busy", 32'(busy), 32'd0);
        step();
        chk("to_err_pulse", 32'(err), 32'd0);
        $display("txn %0d timeout rd_data=%h", txn_no, rd_data);
        txn_no++;
        // Ready in the expiry cycle (4th ACCESS cycle) completes normally
        run_txn(1'b1, 30'h21, 32'h0, 32'h3333_4444, 1, 3, 1'b0, 32'h3333_4444, 6);
`endif

        // Random transactions against the latency/data model
        for (int n = 0; n < 40; n++) begin
            logic        t_rw;
            logic [29:0] t_addr;
            logic [31:0] t_wd;
            logic [31:0] t_rd;
            int          g;
            int          r;
            int          gap;
            t_rw   = 1'($urandom);
            t_addr = 30'($urandom);
            t_wd   = $urandom;
            t_rd   = $urandom;
            g      = int'($urandom_range(0, 5));
            r      = int'($urandom_range(0, 3));
            gap    = int'($urandom_range(0, 2));
            for (int c = 0; c < gap; c++) begin
                // idle cycles: either no strobe, or a strobe killed by flush
                as_ = 1'($urandom);
                flush = !as_;
                settle();
                chk("gap_busy", 32'(busy), 32'd0);
                step();
                chk("gap_req_", 32'(bus.bus_req_), 32'd1);
            end
            run_txn(t_rw, t_addr, t_wd, t_rd, g, r, 1'b0,
                    t_rw ? t_rd : model_rd, 2 + g + r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
